jtag_debug_tap_mux: RTL and testbench
=====================================

// Module: jtag_debug_tap_mux
// PURPOSE
//  Parametrised JTAG debug multiplexer, successor to the fixed single-target debug wrapper.
//  Host TAP (full 1149.1 FSM plus IR) decodes IR codes and connects one of NUM_TGTS
//  downstream target TAPs (e.g. RISC-V DTMs) to the host pins. Clock is gated to idle targets.
//  Sits between the device JTAG pins and the soft-core debug transport modules.
// PARAMETERS
//  NUM_TGTS        1              number of target channels, 1..16
//  IR_WIDTH        8              host IR length, 4..16
//  IR_CODE_BASE    'h55           IR code of target 0; target n = IR_CODE_BASE+n
//  TGT_RST_ACT_HI  16'hFFFF       bit n=1: TGT_TRSTB[n] is active-high, 0: active-low
//  IDCODE_VAL      32'h0000_0001  IDCODE register value (only with the macro; bit0 must be 1)
// PORTS
//  TCK        in   1         JTAG clock, the only clock
//  TRSTB      in   1         async active-low reset
//  TMS        in   1         host TMS
//  TDI        in   1         host TDI
//  TDO        out  1         host TDO
//  TGT_TDO    in   NUM_TGTS  target TDO, bit n = target n
//  TGT_TCK    out  NUM_TGTS  gated TCK per target
//  TGT_TMS    out  NUM_TGTS  TMS per target
//  TGT_TDI    out  NUM_TGTS  TDI per target
//  TGT_TRSTB  out  NUM_TGTS  target reset, polarity per TGT_RST_ACT_HI
//  SEL_VALID  out  1         a target is currently selected (status/debug)
// BEHAVIOUR
//  - Host FSM: 16 standard TAP states, posedge TCK on TMS; reset -> TEST_LOGIC_RESET; 5x TMS=1 reaches TLR.
//  - IR: Capture-IR loads {IR_WIDTH-2 zeros, 2'b01}; Shift-IR shifts LSB first, TDI -> MSB;
//    Update-IR latches ir_q. Reset and TLR set ir_q = all ones (BYPASS).
//  - Selection: at Update-IR, sel_q = n when ir_q == IR_CODE_BASE+n with n<NUM_TGTS, and SEL_VALID=1;
//    any other code clears SEL_VALID. TLR clears it. Codes >= IR_CODE_BASE+NUM_TGTS are invalid.
//  - Clock gate: en_q[n] updates on the TCK negedge to (SEL_VALID && sel_q==n); TGT_TCK[n]=TCK & en_q[n].
//    This is glitch-free. Entry and exit therefore both happen with host and target in Update-IR,
//    which keeps the TAP states in lockstep.
//  - TGT_TMS[n]=TMS and TGT_TDI[n]=TDI for all n. Idle targets see no clock edges.
//  - TDO is updated on the TCK negedge:
//    - Shift-IR: host ir shift LSB.
//    - Shift-DR with selection: TGT_TDO[sel_q], passed through with no negedge stage, so the target's own negedge timing is kept.
//    - Shift-DR without selection: 1-bit BYPASS register, captured 0 in Capture-DR.
//    - Otherwise: TDO=0.
//  - TGT_TRSTB[n] is asserted while TRSTB=0 or the host is in TLR; otherwise deasserted.
//    Output value = asserted XOR !TGT_RST_ACT_HI[n].
//  - Reset values: TDO=0, TGT_TCK=0, en_q=0, SEL_VALID=0, ir_q=all ones, TGT_TRSTB asserted.
//  - TRSTB low mid-scan aborts the scan immediately (async): the selection is lost and all targets are reset.
//  - Re-selecting the same target at Update-IR keeps en_q high continuously, with no clock dropout.
// CONFIGURATION
//  JTAG_DBG_IDCODE_EN
//    Defined: IR code all-ones-minus-one (IDCODE) selects a 32-bit DR. Capture-DR loads IDCODE_VAL and shifts LSB first.
//      Reset/TLR ir_q = IDCODE, so a first DR scan reads IDCODE_VAL.
//    Undefined: that code behaves as BYPASS and the reset IR stays all ones.
// STRUCTURE
//  - Package jtag_dbg_pkg holds:
//    - tap_state_t enum (16 states)
//    - IR capture constant
//    - BYPASS/IDCODE code functions of IR_WIDTH
//    - helper tgt_code(base,n)
//  - Sub-module jtag_tap_fsm: TMS-driven state register plus decoded strobes (capture/shift/update x IR/DR, tlr).
//  - The top holds the IR, selection, clock gates, TDO mux and reset polarity logic.
// TESTING
//  T1 Reset: TRSTB=0 -> TGT_TCK=0, TDO=0, SEL_VALID=0, TGT_TRSTB[0]=1 (act-hi).
//     After release plus 5 TMS=1, the state is TLR.
//  T2 Select: NUM_TGTS=4, shift IR=8'h57 -> after the Update-IR negedge SEL_VALID=1 and only TGT_TCK[2] toggles.
//     DR shift of 32 bits returns TGT_TDO[2].
//  T3 Invalid/bypass: IR=8'h59 (NUM_TGTS=4) -> SEL_VALID=0 and all TGT_TCK stay low.
//     DR shift of 0xA5 followed by 1 bit returns 0 then 0xA5 (1-cycle bypass).
//  T4 Switch: select target 0, then IR=8'h56 -> TGT_TCK[0] stops in Update-IR and TGT_TCK[1] starts the next edge.
//     Re-select 8'h56 -> TGT_TCK[1] shows no dropout.
//  T5 Mid-scan reset: TRSTB low during Shift-DR of target 1 -> SEL_VALID=0, TGT_TCK=0, TGT_TRSTB asserted immediately.
//  T6 IR capture: an IR scan returns 8'h01 in the first 8 TDO bits.
//     With JTAG_DBG_IDCODE_EN, a DR scan after reset returns IDCODE_VAL.

Source files
------------

// File: rtl/jtag_dbg_pkg.sv
// Shared types and code helpers for the JTAG debug multiplexer.
// Host TAP state encoding, IR capture pattern and IR code helpers.
package jtag_dbg_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'h0,
        ST_RTI      = 4'h1,
        ST_SEL_DR   = 4'h2,
        ST_CAP_DR   = 4'h3,
        ST_SHIFT_DR = 4'h4,
        ST_EXIT1_DR = 4'h5,
        ST_PAUSE_DR = 4'h6,
        ST_EXIT2_DR = 4'h7,
        ST_UPD_DR   = 4'h8,
        ST_SEL_IR   = 4'h9,
        ST_CAP_IR   = 4'hA,
        ST_SHIFT_IR = 4'hB,
        ST_EXIT1_IR = 4'hC,
        ST_PAUSE_IR = 4'hD,
        ST_EXIT2_IR = 4'hE,
        ST_UPD_IR   = 4'hF
    } tap_state_t;

    localparam logic [15:0] IR_CAPTURE = 16'h0001;

    function automatic logic [15:0] bypass_code(input int w);
        return 16'((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [15:0] idcode_code(input int w);
        return bypass_code(w) - 16'h0001;
    endfunction

    function automatic logic [15:0] tgt_code(input logic [15:0] base, input int unsigned n);
        return base + n[15:0];
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: TMS-driven state register and decoded state strobes.
module jtag_tap_fsm
    import jtag_dbg_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    output logic tlr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o,
    output logic capture_dr_o,
    output logic shift_dr_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    // TAP state register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TAP transition table
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    assign tlr_o        = (state_q == ST_TLR);
    assign capture_ir_o = (state_q == ST_CAP_IR);
    assign shift_ir_o   = (state_q == ST_SHIFT_IR);
    assign update_ir_o  = (state_q == ST_UPD_IR);
    assign capture_dr_o = (state_q == ST_CAP_DR);
    assign shift_dr_o   = (state_q == ST_SHIFT_DR);

endmodule

// File: rtl/jtag_debug_tap_mux.sv
// Host TAP that routes the JTAG pins to one of NUM_TGTS gated target TAPs.
// Optional IDCODE register enabled by defining JTAG_DBG_IDCODE_EN.
module jtag_debug_tap_mux
    import jtag_dbg_pkg::*;
#(
    parameter int          NUM_TGTS       = 1,
    parameter int          IR_WIDTH       = 8,
    parameter logic [15:0] IR_CODE_BASE   = 16'h0055,
    parameter logic [15:0] TGT_RST_ACT_HI = 16'hFFFF,
    parameter logic [31:0] IDCODE_VAL     = 32'h0000_0001
) (
    input  logic                TCK,
    input  logic                TRSTB,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    input  logic [NUM_TGTS-1:0] TGT_TDO,
    output logic [NUM_TGTS-1:0] TGT_TCK,
    output logic [NUM_TGTS-1:0] TGT_TMS,
    output logic [NUM_TGTS-1:0] TGT_TDI,
    output logic [NUM_TGTS-1:0] TGT_TRSTB,
    output logic                SEL_VALID
);

    localparam int SEL_W = (NUM_TGTS > 1) ? $clog2(NUM_TGTS) : 1;
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = IR_WIDTH'(bypass_code(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(idcode_code(IR_WIDTH));
`ifdef JTAG_DBG_IDCODE_EN
    localparam bit                  IDCODE_EN = 1'b1;
    localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
    localparam bit                  IDCODE_EN = 1'b0;
    localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

    logic tlr_s, capture_ir_s, shift_ir_s, update_ir_s, capture_dr_s, shift_dr_s;

    jtag_tap_fsm u_fsm (
        .tck          (TCK),
        .trst_n       (TRSTB),
        .tms          (TMS),
        .tlr_o        (tlr_s),
        .capture_ir_o (capture_ir_s),
        .shift_ir_o   (shift_ir_s),
        .update_ir_o  (update_ir_s),
        .capture_dr_o (capture_dr_s),
        .shift_dr_o   (shift_dr_s)
    );

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d, ir_q, ir_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_dr_q, idcode_dr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                sel_valid_q, sel_valid_d;
    logic [NUM_TGTS-1:0] en_q, en_d;
    logic                tdo_q, tdo_d, pass_q, pass_d;
    logic                idcode_sel_s, sel_tdo_s;

    // Posedge scan paths: IR shifter, bypass bit and IDCODE shifter
    always_comb begin
        ir_shift_d  = ir_shift_q;
        bypass_d    = bypass_q;
        idcode_dr_d = idcode_dr_q;
        if (capture_ir_s) begin
            ir_shift_d = IR_WIDTH'(IR_CAPTURE);
        end else if (shift_ir_s) begin
            ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
        end else if (capture_dr_s) begin
            bypass_d    = 1'b0;
            idcode_dr_d = IDCODE_VAL;
        end else if (shift_dr_s) begin
            bypass_d    = TDI;
            idcode_dr_d = {TDI, idcode_dr_q[31:1]};
        end else begin
            ir_shift_d = ir_shift_q;
        end
    end

    // Posedge scan registers
    always_ff @(posedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            ir_shift_q  <= IR_BYPASS;
            bypass_q    <= 1'b0;
            idcode_dr_q <= 32'h0000_0000;
        end else begin
            ir_shift_q  <= ir_shift_d;
            bypass_q    <= bypass_d;
            idcode_dr_q <= idcode_dr_d;
        end
    end

    assign idcode_sel_s = IDCODE_EN && (ir_q == IR_IDCODE);

    // Update-IR decode; gate enables follow the new selection on the same negedge
    always_comb begin
        ir_d        = ir_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        if (tlr_s) begin
            ir_d        = IR_RESET;
            sel_valid_d = 1'b0;
        end else if (update_ir_s) begin
            ir_d        = ir_shift_q;
            sel_valid_d = 1'b0;
            for (int n = 0; n < NUM_TGTS; n++) begin
                if (16'(ir_shift_q) == tgt_code(IR_CODE_BASE, unsigned'(n))) begin
                    sel_d       = SEL_W'(n);
                    sel_valid_d = 1'b1;
                end
            end
        end else begin
            ir_d = ir_q;
        end
        for (int n = 0; n < NUM_TGTS; n++) begin
            en_d[n] = sel_valid_d && (sel_d == SEL_W'(n));
        end
        tdo_d  = 1'b0;
        pass_d = 1'b0;
        if (shift_ir_s) begin
            tdo_d = ir_shift_q[0];
        end else if (shift_dr_s) begin
            if (sel_valid_q) begin
                pass_d = 1'b1;
            end else if (idcode_sel_s) begin
                tdo_d = idcode_dr_q[0];
            end else begin
                tdo_d = bypass_q;
            end
        end else begin
            tdo_d = 1'b0;
        end
    end

    // Negedge registers: enables change only while TCK is low, keeping TGT_TCK glitch-free
    always_ff @(negedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            ir_q        <= IR_RESET;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            en_q        <= '0;
            tdo_q       <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            en_q        <= en_d;
            tdo_q       <= tdo_d;
            pass_q      <= pass_d;
        end
    end

    // Selected target TDO, passed through unregistered to keep target timing
    always_comb begin
        sel_tdo_s = 1'b0;
        for (int n = 0; n < NUM_TGTS; n++) begin
            if (sel_q == SEL_W'(n)) begin
                sel_tdo_s = TGT_TDO[n];
            end
        end
    end

    assign TDO       = pass_q ? sel_tdo_s : tdo_q;
    assign SEL_VALID = sel_valid_q;
    assign TGT_TCK   = {NUM_TGTS{TCK}} & en_q;
    assign TGT_TMS   = {NUM_TGTS{TMS}};
    assign TGT_TDI   = {NUM_TGTS{TDI}};
    assign TGT_TRSTB = {NUM_TGTS{!TRSTB || tlr_s}} ^ ~TGT_RST_ACT_HI[NUM_TGTS-1:0];

endmodule

// File: tb/tb_jtag_debug_tap_mux.sv
// Directed bench for jtag_debug_tap_mux with four targets; target 1 uses an active-low reset.
module tb_jtag_debug_tap_mux;

    localparam int          NT     = 4;
    localparam logic [15:0] ACT_HI = 16'hFFFD;
    localparam logic [31:0] IDV    = 32'h1234_5679;
`ifdef JTAG_DBG_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam logic [NT-1:0] RST_ON  = 4'b1101;
    localparam logic [NT-1:0] RST_OFF = 4'b0010;

    logic TCK = 1'b0, TRSTB = 1'b1, TMS = 1'b1, TDI = 1'b0;
    logic TDO, SEL_VALID;
    logic [NT-1:0] TGT_TDO = '0;
    logic [NT-1:0] TGT_TCK, TGT_TMS, TGT_TDI, TGT_TRSTB;

    int total = 0;
    int bad   = 0;
    int tck_cnt [NT] = '{0, 0, 0, 0};
    logic [NT-1:0] tck_prev = '0;
    logic last_tdo = 1'b0;
    logic [31:0] pat [NT] = '{32'h8E3A_61D5, 32'h1B7C_F042, 32'h6D95_2AE8, 32'hF0C3_5B17};

    typedef struct {
        logic [7:0]          ir;
        logic                exp_valid;
        int                  exp_tgt;
        logic [NT-1:0][7:0]  exp_d;
    } vec_t;
    vec_t vecs [10];

    jtag_debug_tap_mux #(
        .NUM_TGTS       (NT),
        .IR_WIDTH       (8),
        .IR_CODE_BASE   (16'h0055),
        .TGT_RST_ACT_HI (ACT_HI),
        .IDCODE_VAL     (IDV)
    ) dut (
        .TCK       (TCK),
        .TRSTB     (TRSTB),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .TGT_TDO   (TGT_TDO),
        .TGT_TCK   (TGT_TCK),
        .TGT_TMS   (TGT_TMS),
        .TGT_TDI   (TGT_TDI),
        .TGT_TRSTB (TGT_TRSTB),
        .SEL_VALID (SEL_VALID)
    );

    always #5 TCK = ~TCK;

    // Count rising edges seen by each gated target clock
    always @(TGT_TCK) begin
        for (int n = 0; n < NT; n++) begin
            if (TGT_TCK[n] && !tck_prev[n]) tck_cnt[n] = tck_cnt[n] + 1;
        end
        tck_prev = TGT_TCK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NT-1:0][7:0] d4(input int c3, input int c2, input int c1, input int c0);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    function automatic logic [NT-1:0] tgt_bits(input int i);
        logic [NT-1:0] b;
        for (int n = 0; n < NT; n++) b[n] = pat[n][i];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi, input logic [NT-1:0] tgt);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        TGT_TDO = tgt;
        #4;
        last_tdo = TDO;
        @(posedge TCK);
        #1;
    endtask

    // From Run-Test/Idle, scan an 8-bit IR and return to Run-Test/Idle
    task automatic shift_ir(input logic [7:0] code, output logic [7:0] cap);
        cap = 8'h00;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            step(i == 7, code[i], '0);
            cap[i] = last_tdo;
        end
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    // From Run-Test/Idle, scan nb DR bits while targets present their patterns
    task automatic shift_dr(input int nb, input logic [31:0] data, output logic [31:0] cap);
        cap = 32'h0;
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < nb; i++) begin
            step(i == nb - 1, data[i], tgt_bits(i));
            cap[i] = last_tdo;
        end
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [7:0]  ir_cap;
        logic [31:0] dr_cap, exp_dr;
        int          snap [NT];

        vecs[0] = '{8'h57, 1'b1, 2, d4(0, 1, 0, 0)};
        vecs[1] = '{8'h59, 1'b0, 0, d4(0, 13, 0, 0)};
        vecs[2] = '{8'h55, 1'b1, 0, d4(0, 0, 0, 1)};
        vecs[3] = '{8'h56, 1'b1, 1, d4(0, 0, 1, 13)};
        vecs[4] = '{8'h56, 1'b1, 1, d4(0, 0, 14, 0)};
        vecs[5] = '{8'h58, 1'b1, 3, d4(1, 0, 13, 0)};
        vecs[6] = '{8'h54, 1'b0, 0, d4(13, 0, 0, 0)};
        vecs[7] = '{8'hFF, 1'b0, 0, d4(0, 0, 0, 0)};
        vecs[8] = '{8'h58, 1'b1, 3, d4(1, 0, 0, 0)};
        vecs[9] = '{8'hFE, 1'b0, 0, d4(13, 0, 0, 0)};

        // Reset state
        #1 TRSTB = 1'b0;
        #12;
        check("rst_tgt_tck", 32'(TGT_TCK), 32'(4'b0000));
        check("rst_tdo", 32'(TDO), 32'(1'b0));
        check("rst_sel_valid", 32'(SEL_VALID), 32'(1'b0));
        check("rst_tgt_trstb", 32'(TGT_TRSTB), 32'(RST_ON));
        @(negedge TCK);
        #2 TRSTB = 1'b1;
        #1;
        check("tlr_after_release", 32'(TGT_TRSTB), 32'(RST_ON));
        step(1'b0, 1'b1, '0);
        check("rti_trstb_off", 32'(TGT_TRSTB), 32'(RST_OFF));
        check("tms_fanout", 32'(TGT_TMS), 32'(4'b0000));
        check("tdi_fanout", 32'(TGT_TDI), 32'(4'b1111));
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        check("five_tms_tlr", 32'(TGT_TRSTB), 32'(RST_ON));
        step(1'b0, 1'b0, '0);

        // First DR scan after reset: IDCODE with the option, else bypass
        shift_dr(32, 32'h5A5A_C3C3, dr_cap);
        exp_dr = ID_EN ? IDV : {31'h5A5A_C3C3 & 31'h7FFF_FFFF, 1'b0};
        check("first_dr_scan", dr_cap, exp_dr);

        // Table: IR selection, clock gating edge counts and DR routing
        for (int v = 0; v < 10; v++) begin
            for (int n = 0; n < NT; n++) snap[n] = tck_cnt[n];
            shift_ir(vecs[v].ir, ir_cap);
            check($sformatf("v%0d_ir_capture", v), 32'(ir_cap), 32'h01);
            check($sformatf("v%0d_sel_valid", v), 32'(SEL_VALID), 32'(vecs[v].exp_valid));
            for (int n = 0; n < NT; n++) begin
                check($sformatf("v%0d_ir_edges_t%0d", v, n), 32'(tck_cnt[n] - snap[n]),
                      32'(vecs[v].exp_d[n]));
                snap[n] = tck_cnt[n];
            end
            shift_dr(9, 32'h0000_00A5, dr_cap);
            if (vecs[v].exp_valid) exp_dr = pat[vecs[v].exp_tgt] & 32'h1FF;
            else if (ID_EN && vecs[v].ir == 8'hFE) exp_dr = IDV & 32'h1FF;
            else exp_dr = 32'h0000_014A;
            check($sformatf("v%0d_dr_data", v), dr_cap, exp_dr);
            for (int n = 0; n < NT; n++) begin
                check($sformatf("v%0d_dr_edges_t%0d", v, n), 32'(tck_cnt[n] - snap[n]),
                      (vecs[v].exp_valid && vecs[v].exp_tgt == n) ? 32'd14 : 32'd0);
            end
        end

        // Full 32-bit DR through target 2
        shift_ir(8'h57, ir_cap);
        shift_dr(32, 32'h0, dr_cap);
        check("t2_dr32", dr_cap, pat[2]);

        // Test-Logic-Reset drops the selection; edges stop once in TLR
        snap[2] = tck_cnt[2];
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        check("tlr_sel_valid", 32'(SEL_VALID), 32'(1'b0));
        check("tlr_edges_t2", 32'(tck_cnt[2] - snap[2]), 32'd3);
        step(1'b0, 1'b0, '0);

        // Asynchronous reset in the middle of a target-1 DR scan
        shift_ir(8'h56, ir_cap);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, tgt_bits(0));
        check("midscan_pre_tck", 32'(TGT_TCK), 32'(4'b0010));
        TRSTB = 1'b0;
        #1;
        check("midscan_tgt_tck", 32'(TGT_TCK), 32'(4'b0000));
        check("midscan_sel_valid", 32'(SEL_VALID), 32'(1'b0));
        check("midscan_trstb", 32'(TGT_TRSTB), 32'(RST_ON));
        check("midscan_tdo", 32'(TDO), 32'(1'b0));
        @(negedge TCK);
        #2 TRSTB = 1'b1;
        step(1'b0, 1'b0, '0);
        shift_dr(9, 32'h0000_0033, dr_cap);
        exp_dr = ID_EN ? (IDV & 32'h1FF) : 32'h0000_0066;
        check("post_reset_dr", dr_cap, exp_dr);
        check("post_reset_sel_valid", 32'(SEL_VALID), 32'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
